// File: rtl/ip_dec_rx_pkg.sv
// Shared types and constants for the tagged-byte receive path of the XTEA decrypt engine.
package ip_dec_pkg;

    localparam int BYTE_W  = 8;
    localparam int TAG_W   = 2;
    localparam int BEAT_W  = 10;
    localparam int BLOCK_W = 128;

    localparam logic [0:0] ST_SYNC    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    typedef enum logic [0:0] {
        SYNC    = ST_SYNC,
        COLLECT = ST_COLLECT
    } rx_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [BYTE_W-1:0] payload;
    } beat_t;

endpackage

// File: rtl/ip_dec_rx_if.sv
// Link beat input and ciphertext block output of ip_dec_rx; slave is the receiver side.
interface ip_dec_rx_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [9:0]               data_in;
    logic                     req;
    logic [8*BLOCK_BYTES-1:0] block_out;
    logic                     block_valid;
    logic                     block_ready;
    logic                     seq_err;
    logic                     overflow;
    logic                     busy;

    modport master (
        output data_in, req, block_ready,
        input  block_out, block_valid, seq_err, overflow, busy
    );

    modport slave (
        input  data_in, req, block_ready,
        output block_out, block_valid, seq_err, overflow, busy
    );
endinterface

// File: rtl/ip_dec_rx_outbuf.sv
// Single-entry valid/ready holding register for completed blocks; drops and flags overflow when full.
module ip_dec_rx_outbuf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         overflow
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (load && (!valid || ready)) begin
            // A consume and a new load in the same cycle keep valid asserted.
            dout  <= din;
            valid <= 1'b1;
        end else if (load) begin
            overflow <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ip_dec_rx.sv
// Tag-checked byte reassembly into ciphertext blocks, MSB-first.
// Optional idle-abort of partial blocks under `IP_DEC_RX_TIMEOUT_EN.
module ip_dec_rx
    import ip_dec_pkg::*;
#(
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    ip_dec_rx_if.slave  bus
);

    localparam int W     = BYTE_W * BLOCK_BYTES;
    localparam int IDX_W = $clog2(BLOCK_BYTES);

    if (BLOCK_BYTES % 4 != 0 || BLOCK_BYTES < 4) begin : g_bad_block
        $error("BLOCK_BYTES must be a non-zero multiple of 4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    beat_t            beat;
    rx_state_e        state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     asm_r;
    logic [W-1:0]     asm_next;
    logic             tag_ok;
    logic             last;
    logic             complete;
    logic             seq_err_r;
    logic             busy;
    logic             timeout;

    assign beat     = beat_t'(bus.data_in);
    assign tag_ok   = beat.tag == idx[1:0];
    assign last     = idx == IDX_W'(BLOCK_BYTES - 1);
    assign asm_next = {asm_r[W-BYTE_W-1:0], beat.payload};
    assign complete = bus.req && state == COLLECT && tag_ok && last;
    assign busy     = idx != '0;

`ifdef IP_DEC_RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a partial block.
    assign timeout = !bus.req && busy && idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset || bus.req || !busy) idle_cnt <= '0;
        else                           idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC;
            idx       <= '0;
            asm_r     <= '0;
            seq_err_r <= 1'b0;
        end else begin
            seq_err_r <= 1'b0;
            if (bus.req) begin
                if (state == SYNC) begin
                    if (beat.tag == '0) begin
                        asm_r <= asm_next;
                        idx   <= IDX_W'(1);
                        state <= COLLECT;
                    end
                end else if (tag_ok) begin
                    asm_r <= asm_next;
                    idx   <= last ? '0 : idx + 1'b1;
                end else begin
                    // A tag-0 beat on a mismatch is a fresh block start, so no resync gap.
                    seq_err_r <= 1'b1;
                    if (beat.tag == '0) begin
                        asm_r <= asm_next;
                        idx   <= IDX_W'(1);
                    end else begin
                        idx   <= '0;
                        state <= SYNC;
                    end
                end
            end else if (timeout) begin
                idx       <= '0;
                state     <= SYNC;
                seq_err_r <= 1'b1;
            end
        end
    end

    assign bus.seq_err = seq_err_r;
    assign bus.busy    = busy;

    ip_dec_rx_outbuf #(.W(W)) u_outbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (complete),
        .din      (asm_next),
        .ready    (bus.block_ready),
        .dout     (bus.block_out),
        .valid    (bus.block_valid),
        .overflow (bus.overflow)
    );

endmodule

// File: tb/tb_ip_dec_rx.sv
// Directed bench for ip_dec_rx: clean blocks, tag errors, back-pressure, reset and idle timeout.
module tb_ip_dec_rx;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    int   se_cnt = 0;
    int   v_cnt  = 0;

    localparam logic [127:0] BLK_A = 128'h089975E92555F334CE76E4F24D932AB3;
    localparam logic [127:0] BLK_B = 128'hB32A934DF2E476CE34F35525E9759908;
    localparam logic [127:0] BLK_C = 128'h000102030405060708090A0B0C0D0E0F;

    ip_dec_rx_if #(.BLOCK_BYTES(16)) bus ();

    ip_dec_rx #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counts cycles in which the pulse/valid was high, sampled before each edge updates them.
    always @(posedge clk) begin
        if (bus.seq_err)     se_cnt <= se_cnt + 1;
        if (bus.block_valid) v_cnt  <= v_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] b);
        bus.data_in = {t, b};
        bus.req     = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_blk(input logic [127:0] blk, input int n);
        for (int i = 0; i < n; i++) send(2'(i), blk[127-8*i -: 8]);
    endtask

    task automatic idle(input int n);
        bus.req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clr();
        se_cnt = 0;
        v_cnt  = 0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.req         = 1'b0;
        bus.data_in     = '0;
        bus.block_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_block_out", bus.block_out, '0);
        chk("rst_valid", 128'(bus.block_valid), 128'd0);
        chk("rst_seq_err", 128'(bus.seq_err), 128'd0);
        chk("rst_overflow", 128'(bus.overflow), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Clean block, consumer always ready
        clr();
        bus.block_ready = 1'b1;
        send_blk(BLK_A, 7);
        chk("t1_busy_mid", 128'(bus.busy), 128'd1);
        for (int i = 7; i < 16; i++) send(2'(i), BLK_A[127-8*i -: 8]);
        chk("t1_block", bus.block_out, BLK_A);
        chk("t1_valid", 128'(bus.block_valid), 128'd1);
        chk("t1_busy_done", 128'(bus.busy), 128'd0);
        idle(1);
        chk("t1_valid_drop", 128'(bus.block_valid), 128'd0);
        chk("t1_valid_cycles", 128'(v_cnt), 128'd1);
        chk("t1_seq_err_cnt", 128'(se_cnt), 128'd0);
        chk("t1_overflow", 128'(bus.overflow), 128'd0);

        // Beat 5 tagged 3: error, SYNC drops beats 6-7, beat 8 (tag 0) restarts a partial block
        clr();
        send_blk(BLK_A, 5);
        send(2'd3, BLK_A[127-40 -: 8]);
        chk("t2_seq_err_pulse", 128'(bus.seq_err), 128'd1);
        for (int i = 6; i < 16; i++) send(2'(i), BLK_A[127-8*i -: 8]);
        idle(1);
        chk("t2_seq_err_cnt", 128'(se_cnt), 128'd1);
        chk("t2_no_valid", 128'(v_cnt), 128'd0);
        chk("t2_resync_busy", 128'(bus.busy), 128'd1);
        send(2'd1, 8'h55);
        chk("t2_stray_err", 128'(bus.seq_err), 128'd1);
        chk("t2_stray_busy", 128'(bus.busy), 128'd0);
        send_blk(BLK_C, 16);
        chk("t2_clean_block", bus.block_out, BLK_C);
        chk("t2_clean_valid", 128'(bus.block_valid), 128'd1);
        idle(1);

        // Back-pressure: second block is dropped and flagged
        do_reset();
        bus.block_ready = 1'b0;
        send_blk(BLK_A, 16);
        chk("t3_first_valid", 128'(bus.block_valid), 128'd1);
        chk("t3_first_block", bus.block_out, BLK_A);
        send_blk(BLK_B, 8);
        chk("t3_held_mid", bus.block_out, BLK_A);
        for (int i = 8; i < 16; i++) send(2'(i), BLK_B[127-8*i -: 8]);
        chk("t3_held_block", bus.block_out, BLK_A);
        chk("t3_overflow", 128'(bus.overflow), 128'd1);
        chk("t3_still_valid", 128'(bus.block_valid), 128'd1);
        bus.block_ready = 1'b1;
        idle(1);
        chk("t3_valid_fall", 128'(bus.block_valid), 128'd0);
        chk("t3_overflow_sticky", 128'(bus.overflow), 128'd1);
        bus.block_ready = 1'b0;

        // Ready raised on the cycle B completes: A consumed, B loaded
        do_reset();
        send_blk(BLK_A, 16);
        send_blk(BLK_B, 15);
        chk("t4_a_held", bus.block_out, BLK_A);
        bus.block_ready = 1'b1;
        send(2'd3, BLK_B[7:0]);
        chk("t4_valid_kept", 128'(bus.block_valid), 128'd1);
        chk("t4_b_loaded", bus.block_out, BLK_B);
        chk("t4_no_overflow", 128'(bus.overflow), 128'd0);
        idle(1);
        chk("t4_b_consumed", 128'(bus.block_valid), 128'd0);

        // Reset mid-block
        send_blk(BLK_A, 7);
        reset   = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("t5_rst_block_out", bus.block_out, '0);
        chk("t5_rst_valid", 128'(bus.block_valid), 128'd0);
        chk("t5_rst_overflow", 128'(bus.overflow), 128'd0);
        chk("t5_rst_busy", 128'(bus.busy), 128'd0);
        chk("t5_rst_seq_err", 128'(bus.seq_err), 128'd0);
        reset = 1'b0;
        send_blk(BLK_C, 16);
        chk("t5_block", bus.block_out, BLK_C);
        chk("t5_valid", 128'(bus.block_valid), 128'd1);
        idle(1);

        // Idle gap inside a partial block
        do_reset();
        clr();
        send_blk(BLK_A, 5);
        idle(16);
`ifdef IP_DEC_RX_TIMEOUT_EN
        chk("t6_busy_after_idle", 128'(bus.busy), 128'd0);
        idle(1);
        chk("t6_timeout_pulses", 128'(se_cnt), 128'd1);
`else
        chk("t6_busy_after_idle", 128'(bus.busy), 128'd1);
        idle(1);
        chk("t6_timeout_pulses", 128'(se_cnt), 128'd0);
`endif
        send_blk(BLK_B, 16);
        chk("t6_block", bus.block_out, BLK_B);
        chk("t6_valid", 128'(bus.block_valid), 128'd1);
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
